adc_spi_responder: RTL
======================

Name: adc_spi_responder

Overview:
- Synthesizable model of the board's 8-channel, 12-bit serial ADC, acting as the SPI responder. It is driven by the system's adc_sclk/adc_cs_n/adc_din master outputs and returns adc_dout.
- Used in loopback/emulation builds and in system-level simulation in place of the physical ADC. It takes parallel channel values from the fabric.
- Protocol is LTC2308-style: a 6-bit config word is shifted in and the previous 12-bit result is shifted out in the same frame. The rising edge of cs_n starts the conversion.

Parameters:
- CONV_CYCLES, 64, clk cycles from cs_n rising edge to result-register update (min 2).
- SYNC_STAGES, 2, synchronizer flops on adc_sclk/adc_cs_n/adc_din (min 2).

Ports:
- clk  input  1  system clock; must be at least 4x adc_sclk frequency.
- reset_n  input  1  asynchronous, active-low reset.
- adc_sclk  input  1  serial clock from master; idles low.
- adc_cs_n  input  1  frame select/convert start, active low.
- adc_din  input  1  config bits from master, MSB first.
- adc_dout  output  1  result bits to master, MSB first.
- ch_data  input  96  eight 12-bit channel values; channel n occupies [12n+11:12n].
- cfg_word  output  6  last accepted config {S/D,O/S,S1,S0,UNI,SLP}.
- conv_busy  output  1  high while a conversion is in progress.
- conv_done  output  1  one-clk pulse when the result register updates.
- frame_err  output  1  one-clk pulse on an aborted or overlapping frame.

Behaviour:
- Reset values (async assert, sync release to clk):
  - adc_dout=0, cfg_word=6'b100010 (single-ended, CH0, unipolar, awake).
  - conv_busy=0, conv_done=0, frame_err=0.
  - Result register=0, bit counter=0, state IDLE.
- All three serial inputs pass through SYNC_STAGES flops. Edges are detected on the synchronized sclk/cs_n; all logic runs on clk only.
- IDLE:
  - cs_n falling edge → SHIFT. Load the shift-out register with the result and drive result[11] on adc_dout the next clk. Clear the bit counter.
  - sclk edges in IDLE are ignored. adc_dout holds its last value.
- SHIFT:
  - Each sclk rising edge: if counter<6, shift din into the config shift register. Increment the counter, saturating at 15.
  - Each sclk falling edge: if counter<12, present the next result bit on adc_dout. After bit 0 is sent, adc_dout=0.
  - cs_n rising edge with counter>=6: latch the 6 captured bits into cfg_word.
    - If the new SLP=1 → IDLE with no conversion.
    - Otherwise → CONVERT, with conv_busy=1 on the next clk.
  - cs_n rising edge with counter<6: frame_err pulse, cfg_word unchanged, → IDLE, no conversion.
- CONVERT:
  - A down-counter is loaded with CONV_CYCLES-1. At 0, the result register is loaded from the selected channel (sampled at that clk).
  - In that same clk: conv_done=1, then conv_busy=0 and → IDLE. Latency from cs_n rise (synchronized) to conv_done is exactly CONV_CYCLES clks.
  - cs_n falling edge during CONVERT: frame_err pulse. The conversion completes normally and that frame is ignored (adc_dout=0 for its duration); the responder returns to IDLE only after cs_n is next high.
- Channel select: ch = {S1,S0,O/S}. Single-ended mapping is O/S=0→CH0/2/4/6 and O/S=1→CH1/3/5/7. S/D=0 (differential) uses the same index; the differential pair is not modelled.
- Data format:
  - UNI=1: result = ch_data slice, straight binary.
  - UNI=0: result = slice XOR 12'h800 (two's complement).
- The result loaded into the result register is the one returned by the next frame (one-frame pipeline). The first frame after reset returns 0.
- Mid-operation reset: everything returns to reset values immediately. A frame in progress is discarded. After release, the responder waits in IDLE for a fresh cs_n fall; if cs_n is low at release, it waits for a rise first.

Test Plan:
- After reset, frame with din=6'b100010 (CH0, UNI), ch0=12'hABC, SCLK=clk/8 → dout bits all 0; conv_done pulse exactly CONV_CYCLES clks after cs_n rise; next frame shifts out 1010_1011_1100.
- Config 6'b110010 (O/S=1, CH1), ch1=12'h123 → following frame returns 12'h123; cfg_word=6'b110010.
- Config with UNI=0 on CH0 (6'b100000), ch0=12'h005 → next frame returns 12'h805.
- cs_n raised after 4 sclk cycles → frame_err pulse, cfg_word unchanged, no conv_done, conv_busy stays 0.
- cs_n lowered 10 clks into CONVERT (CONV_CYCLES=64) → frame_err pulse, dout=0 during that frame, conv_done still at cycle 64, subsequent frame returns new result.
- SLP=1 config (6'b100011) → no conv_done, result unchanged. reset_n asserted mid-SHIFT → adc_dout=0 at once; the post-release frame returns 0.

Source files
------------

// File: rtl/adc_spi_responder.sv
// rtl/adc_spi_responder.sv - LTC2308-style 8-channel 12-bit ADC emulated as an SPI responder
module adc_spi_responder #(
  parameter int CONV_CYCLES = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        adc_sclk,
  input  logic        adc_cs_n,
  input  logic        adc_din,
  output logic        adc_dout,
  input  logic [95:0] ch_data,
  output logic [5:0]  cfg_word,
  output logic        conv_busy,
  output logic        conv_done,
  output logic        frame_err
);

  localparam int CW = $clog2(CONV_CYCLES);

  // DRAIN swallows the tail of a frame that was started during a conversion.
  typedef enum logic [1:0] {IDLE, SHIFT, CONVERT, DRAIN} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, din_sync;
  logic                   sclk_prev, cs_prev;
  logic                   sclk_s, cs_s, din_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [3:0]    bit_cnt;
  logic [5:0]    cfg_sr;
  logic [10:0]   out_sr;
  logic [11:0]   result;
  logic [CW-1:0] conv_cnt;
  logic [2:0]    ch_idx;
  logic [11:0]   ch_slice;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign din_s     = din_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign cs_fall   = ~cs_s & cs_prev;

  // Channel index is {S1,S0,O/S}; differential mode reuses the same index.
  assign ch_idx   = {cfg_word[3], cfg_word[2], cfg_word[4]};
  assign ch_slice = ch_data[12*ch_idx +: 12];

  // Input synchronizers; cs_n resets low so a frame already open at release is never seen as a fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      din_sync  <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], adc_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], adc_cs_n};
      din_sync  <= {din_sync[SYNC_STAGES-2:0], adc_din};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode from synchronized frame edges and conversion countdown.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = SHIFT;
      SHIFT: begin
        if (cs_rise) begin
          if (bit_cnt >= 4'd6 && !cfg_sr[0]) state_nxt = CONVERT;
          else                               state_nxt = IDLE;
        end
      end
      CONVERT: if (conv_cnt == '0) state_nxt = cs_s ? IDLE : DRAIN;
      DRAIN:   if (cs_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift registers, config latch, conversion timer and status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      adc_dout  <= 1'b0;
      cfg_word  <= 6'b100010;
      conv_busy <= 1'b0;
      conv_done <= 1'b0;
      frame_err <= 1'b0;
      result    <= '0;
      bit_cnt   <= '0;
      cfg_sr    <= '0;
      out_sr    <= '0;
      conv_cnt  <= '0;
    end else begin
      conv_done <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            out_sr   <= result[10:0];
            adc_dout <= result[11];
            bit_cnt  <= '0;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            if (bit_cnt < 4'd6) cfg_sr <= {cfg_sr[4:0], din_s};
            if (bit_cnt != 4'hF) bit_cnt <= bit_cnt + 4'd1;
          end
          if (sclk_fall) begin
            if (bit_cnt < 4'd12) begin
              adc_dout <= out_sr[10];
              out_sr   <= {out_sr[9:0], 1'b0};
            end else begin
              adc_dout <= 1'b0;
            end
          end
          if (cs_rise) begin
            if (bit_cnt >= 4'd6) begin
              cfg_word <= cfg_sr;
              if (!cfg_sr[0]) begin
                conv_busy <= 1'b1;
                conv_cnt  <= CW'(CONV_CYCLES - 1);
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        CONVERT: begin
          if (cs_fall) begin
            frame_err <= 1'b1;
            adc_dout  <= 1'b0;
          end
          if (conv_cnt == '0) begin
            result    <= cfg_word[1] ? ch_slice : (ch_slice ^ 12'h800);
            conv_done <= 1'b1;
            conv_busy <= 1'b0;
          end else begin
            conv_cnt <= conv_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
